// File: rtl/eda_pkg.sv
// Shared window geometry for the neighbour push stage: offsets of the 8 neighbours,
// the linear address helper and the lowest-set-bit encoder.
package eda_pkg;

  localparam int NEIGH_CNT = 8;

  // Row/column offsets indexed by mask bit k (window position 4, the centre, is skipped).
  localparam int NEIGH_DR [0:NEIGH_CNT-1] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  localparam int NEIGH_DC [0:NEIGH_CNT-1] = '{-1, 0, 1, -1, 1, -1, 0, 1};

  function automatic logic [31:0] neigh_addr(input logic [31:0] center, input logic [2:0] k,
                                             input int n);
    return center + 32'(NEIGH_DR[k] * n + NEIGH_DC[k]);
  endfunction

  function automatic logic [2:0] lowest_set(input logic [NEIGH_CNT-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = NEIGH_CNT - 1; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/eda_addr_fifo.sv
// Show-ahead circular FIFO: head visible combinationally, 1-cycle write-to-read latency.
// Writes are refused while full (even with a concurrent pop); pops while empty set sticky pop_err.
module eda_addr_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          pop_err
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [CW-1:0] count_nxt;

  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign pop_dat   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      pop_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
      if (pop && empty) pop_err <= 1'b1;
    end
  end

endmodule

// File: rtl/eda_neigh_push.sv
// Serializes the comparator's push mask lowest-first into neighbour addresses in a FIFO;
// one push per cycle, visible after the edge; stalls with mask bits pending while the FIFO is full.
module eda_neigh_push
  import eda_pkg::*;
#(
  parameter int M            = 16,
  parameter int N            = 16,
  parameter int WINDOW_WIDTH = 9,
  parameter int ADDR_WIDTH   = $clog2(M * N),
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_WIDTH    = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_pixel,
  input  logic [ADDR_WIDTH-1:0]   center_addr,
  input  logic [WINDOW_WIDTH-2:0] push_positions,
  output logic [WINDOW_WIDTH-2:0] iterated_idx,
  input  logic                    pop,
  output logic [ADDR_WIDTH-1:0]   pop_addr,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic [CNT_WIDTH-1:0]    fifo_count,
  output logic                    busy,
  output logic                    pop_err
);

  localparam int MW = WINDOW_WIDTH - 1;

  logic                  push_en;
  logic [2:0]            sel_k;
  logic [ADDR_WIDTH-1:0] sel_addr;

  assign busy     = |push_positions;
  assign push_en  = busy & ~fifo_full & ~new_pixel;
  assign sel_k    = lowest_set(push_positions);
  assign sel_addr = ADDR_WIDTH'(neigh_addr(32'(center_addr), sel_k, N));

  // The comparator drops bit k one cycle later, once it sees it here.
  always_ff @(posedge clk) begin
    if (reset || new_pixel) begin
      iterated_idx <= '0;
    end else if (push_en) begin
      iterated_idx <= iterated_idx | (MW'(1) << sel_k);
    end
  end

  eda_addr_fifo #(
    .DW    (ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (CNT_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_en),
    .push_dat (sel_addr),
    .pop      (pop),
    .pop_dat  (pop_addr),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count),
    .pop_err  (pop_err)
  );

endmodule

// File: tb/tb_eda_neigh_push.sv
// Directed bench for eda_neigh_push; the upstream comparator is modelled as mask & ~iterated_idx.
module tb_eda_neigh_push;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_pixel;
  logic [7:0] center_addr;
  logic [7:0] cmp_mask;
  logic [7:0] push_positions;
  logic [7:0] iterated_idx;
  logic       pop;
  logic [7:0] pop_addr;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       busy;
  logic       pop_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign push_positions = cmp_mask & ~iterated_idx;

  eda_neigh_push dut (
    .clk            (clk),
    .reset          (reset),
    .new_pixel      (new_pixel),
    .center_addr    (center_addr),
    .push_positions (push_positions),
    .iterated_idx   (iterated_idx),
    .pop            (pop),
    .pop_addr       (pop_addr),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .fifo_count     (fifo_count),
    .busy           (busy),
    .pop_err        (pop_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] c, input logic [7:0] m);
    center_addr = c;
    cmp_mask    = m;
    new_pixel   = 1'b1;
    step();
    new_pixel = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; new_pixel = 1'b0; pop = 1'b0; center_addr = '0; cmp_mask = '0;
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", fifo_full); end
    checks++; if (iterated_idx !== 8'h00) begin errors++; $display("FAIL rst_iter: got %h want 00", iterated_idx); end
    checks++; if (pop_err !== 1'b0) begin errors++; $display("FAIL rst_poperr: got %b want 0", pop_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_mapping();
    load(8'h45, 8'b1000_0001);
    step();
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL map_count1: got %0d want 1", fifo_count); end
    checks++; if (iterated_idx !== 8'b0000_0001) begin errors++; $display("FAIL map_iter1: got %b want 00000001", iterated_idx); end
    checks++; if (pop_addr !== 8'h34) begin errors++; $display("FAIL map_head1: got %h want 34", pop_addr); end
    step();
    checks++; if (fifo_count !== 5'd2) begin errors++; $display("FAIL map_count2: got %0d want 2", fifo_count); end
    checks++; if (iterated_idx !== 8'b1000_0001) begin errors++; $display("FAIL map_iter2: got %b want 10000001", iterated_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL map_busy: got %b want 0", busy); end
    pop = 1'b1;
    step();
    checks++; if (pop_addr !== 8'h56) begin errors++; $display("FAIL map_head2: got %h want 56", pop_addr); end
    step();
    pop = 1'b0;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL map_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_all_neighbours();
    logic [7:0] exp [8] = '{8'h34, 8'h35, 8'h36, 8'h44, 8'h46, 8'h54, 8'h55, 8'h56};
    load(8'h45, 8'hFF);
    for (int i = 0; i < 7; i++) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL all_busy7: got %b want 1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL all_busy8: got %b want 0", busy); end
    checks++; if (fifo_count !== 5'd8) begin errors++; $display("FAIL all_count: got %0d want 8", fifo_count); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (pop_addr !== exp[i]) begin errors++; $display("FAIL all_order[%0d]: got %h want %h", i, pop_addr, exp[i]); end
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
  endtask

  task automatic test_full_stall();
    logic [7:0] exp [16] = '{8'h35, 8'h36, 8'h44, 8'h46, 8'h54, 8'h55, 8'h56, 8'h77,
                             8'h78, 8'h79, 8'h87, 8'h89, 8'h97, 8'h98, 8'h77, 8'h78};
    load(8'h45, 8'hFF);
    for (int i = 0; i < 8; i++) step();
    load(8'h88, 8'h7F);
    for (int i = 0; i < 7; i++) step();
    checks++; if (fifo_count !== 5'd15) begin errors++; $display("FAIL full_preload: got %0d want 15", fifo_count); end
    load(8'h88, 8'b0000_0011);
    step();
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", fifo_full); end
    checks++; if (iterated_idx !== 8'b0000_0001) begin errors++; $display("FAIL full_iter: got %b want 00000001", iterated_idx); end
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1", busy); end
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_hold: got %0d want 16", fifo_count); end
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++; if (fifo_count !== 5'd15) begin errors++; $display("FAIL full_popblk: got %0d want 15", fifo_count); end
    checks++; if (iterated_idx !== 8'b0000_0001) begin errors++; $display("FAIL full_popiter: got %b want 00000001", iterated_idx); end
    step();
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_final: got %0d want 16", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_done: got %b want 0", busy); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (pop_addr !== exp[i]) begin errors++; $display("FAIL full_order[%0d]: got %h want %h", i, pop_addr, exp[i]); end
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL full_drained: got %b want 1", fifo_empty); end
  endtask

  task automatic test_new_pixel();
    center_addr = 8'h45; cmp_mask = 8'b0000_0100; new_pixel = 1'b1;
    step();
    new_pixel = 1'b0;
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL np_nowrite: got %0d want 0", fifo_count); end
    checks++; if (iterated_idx !== 8'h00) begin errors++; $display("FAIL np_iter0: got %h want 00", iterated_idx); end
    step();
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL np_write: got %0d want 1", fifo_count); end
    checks++; if (pop_addr !== 8'h36) begin errors++; $display("FAIL np_addr: got %h want 36", pop_addr); end
    checks++; if (iterated_idx !== 8'b0000_0100) begin errors++; $display("FAIL np_iter: got %b want 00000100", iterated_idx); end
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic test_wrap_pop_err();
    logic [7:0] q [$];
    logic [7:0] c;
    logic [7:0] exp;
    int offs [8] = '{-17, -16, -15, -1, 1, 15, 16, 17};
    bit done;
    c = 8'h45;
    for (int i = 0; i < 40; i++) begin
      new_pixel = 1'b0; pop = 1'b0;
      if (i % 2 == 1 && !fifo_empty) begin
        exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
        checks++; if (pop_addr !== exp) begin errors++; $display("FAIL wrap_order[%0d]: got %h want %h", i, pop_addr, exp); end
        pop = 1'b1;
      end
      if (!busy) begin
        c = c + 8'h13;
        center_addr = c; cmp_mask = 8'hFF; new_pixel = 1'b1;
        for (int j = 0; j < 8; j++) q.push_back(c + 8'(offs[j]));
      end
      step();
    end
    new_pixel = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      pop = 1'b0;
      if (!busy && fifo_empty) begin
        done = 1'b1;
      end else begin
        if (!fifo_empty) begin
          exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
          checks++; if (pop_addr !== exp) begin errors++; $display("FAIL wrap_drain: got %h want %h", pop_addr, exp); end
          pop = 1'b1;
        end
        step();
      end
    end
    pop = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL wrap_timeout: got busy=%b empty=%b want drained", busy, fifo_empty); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL wrap_left: got %0d want 0 entries outstanding", q.size()); end
    pop = 1'b1;
    step();
    pop = 1'b0;
    checks++; if (pop_err !== 1'b1) begin errors++; $display("FAIL poperr_set: got %b want 1", pop_err); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL poperr_count: got %0d want 0", fifo_count); end
    step(); step();
    checks++; if (pop_err !== 1'b1) begin errors++; $display("FAIL poperr_sticky: got %b want 1", pop_err); end
  endtask

  task automatic test_reset_mid_drain();
    load(8'h45, 8'hFF);
    step(); step(); step();
    reset = 1'b1;
    #2;
    checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL rmid_async_count: got %0d want 3", fifo_count); end
    checks++; if (pop_err !== 1'b1) begin errors++; $display("FAIL rmid_async_err: got %b want 1", pop_err); end
    step();
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b want 1", fifo_empty); end
    checks++; if (iterated_idx !== 8'h00) begin errors++; $display("FAIL rmid_iter: got %h want 00", iterated_idx); end
    checks++; if (pop_err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", pop_err); end
    reset = 1'b0;
    step();
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL rmid_resume: got %0d want 1", fifo_count); end
    checks++; if (pop_addr !== 8'h34) begin errors++; $display("FAIL rmid_addr: got %h want 34", pop_addr); end
  endtask

  initial begin
    test_reset();
    test_mapping();
    test_all_neighbours();
    test_full_stall();
    test_new_pixel();
    test_wrap_pop_err();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
